// File: rtl/pipe_stage_ctrl_if.sv
// Handshake and bus bundle between the pipeline controller and the stage datapaths.
// The pipeline side (master) drives the stage status and outgoing buses; the
// controller (slave) returns per-stage valid/allow_in/advance and the stage input registers.
interface pipe_stage_ctrl_if #(
  parameter int STAGES = 5,
  parameter int DATA_W = 64
);
  logic [STAGES-1:0]            stage_over;
  logic [(STAGES-1)*DATA_W-1:0] stage_bus;
  logic                         flush;
  logic [STAGES-1:0]            flush_mask;
  logic [STAGES-1:0]            stage_valid;
  logic [STAGES-1:0]            allow_in;
  logic [STAGES-1:0]            advance;
  logic [(STAGES-1)*DATA_W-1:0] stage_bus_r;
  logic                         next_fetch;

  modport master (
    output stage_over, stage_bus, flush, flush_mask,
    input  stage_valid, allow_in, advance, stage_bus_r, next_fetch
  );

  modport slave (
    input  stage_over, stage_bus, flush, flush_mask,
    output stage_valid, allow_in, advance, stage_bus_r, next_fetch
  );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// N-stage pipeline handshake controller with inter-stage bus registers.
// Stage 0 is fetch (always valid once out of reset, no input register); stage i>=1
// owns an input register loaded from stage i-1 on hand-off. A flush clears the valid
// bits of the stages selected by flush_mask while unselected stages keep flowing.
// Optional feature macro: PIPE_PERF_EN adds retire and stall performance counters.
module pipe_stage_ctrl #(
  parameter int STAGES = 5,
  parameter int DATA_W = 64
) (
  input  logic               clk,
  input  logic               reset,
  pipe_stage_ctrl_if.slave   pif
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]        perf_retired,
  output logic [31:0]        perf_stall
`endif
);

  logic [STAGES-1:0]            valid_q;
  logic [STAGES-1:0]            over_q;
  logic [STAGES-1:0]            allow_in;
  logic [STAGES-1:0]            advance;
  logic [(STAGES-1)*DATA_W-1:0] bus_q;

  // Fetch is never flushed, so its mask bit has no function.
  logic unused_mask0;
  assign unused_mask0 = pif.flush_mask[0];

  // A stage only counts as finished when it actually holds an instruction.
  assign over_q = pif.stage_over & valid_q;

  // Back-pressure chain: allow_in ripples from the last stage toward fetch in one cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    allow_in = '0;
    advance  = '0;
    allow_in[STAGES-1] = ~valid_q[STAGES-1] | over_q[STAGES-1];
    advance[STAGES-1]  = over_q[STAGES-1];
    for (int i = STAGES - 2; i >= 1; i--) begin
      allow_in[i] = ~valid_q[i] | (over_q[i] & allow_in[i+1]);
    end
    for (int i = 0; i < STAGES - 1; i++) begin
      advance[i] = over_q[i] & allow_in[i+1];
    end
    // A flush redirects fetch, so the fetch PC must step regardless of downstream state.
    allow_in[0] = (over_q[0] & allow_in[1]) | pif.flush;
  end

  // Valid bits: reset, then flush of selected stages, then normal hand-off, else hold.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= 1'b1;
      for (int i = 1; i < STAGES; i++) begin
        if (pif.flush && pif.flush_mask[i]) begin
          valid_q[i] <= 1'b0;
        end else if (allow_in[i]) begin
          valid_q[i] <= over_q[i-1];
        end
      end
    end
  end

  // Stage input registers load on hand-off and hold through stalls.
  always_ff @(posedge clk) begin
    // NOTE: these data registers are reset deliberately so a fresh pipe presents zeros downstream.
    if (reset) begin
      bus_q <= '0;
    end else begin
      for (int i = 0; i < STAGES - 1; i++) begin
        if (advance[i]) begin
          bus_q[i*DATA_W +: DATA_W] <= pif.stage_bus[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign pif.stage_valid = valid_q;
  assign pif.allow_in    = allow_in;
  assign pif.advance     = advance;
  assign pif.stage_bus_r = bus_q;
  assign pif.next_fetch  = allow_in[0];

`ifdef PIPE_PERF_EN
  logic stall_any;
  assign stall_any = |(valid_q[STAGES-1:1] & ~allow_in[STAGES-1:1]);

  // Retire and stall counters; a flush cycle is neither a retirement nor a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else if (!pif.flush) begin
      if (advance[STAGES-1]) perf_retired <= perf_retired + 32'd1;
      if (stall_any)         perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl with STAGES=5, DATA_W=8.
// Fetch emits an incrementing tag; each later stage forwards its input register.
// Tags are queued at fetch hand-off and must retire in the same order.
module tb_pipe_stage_ctrl;
  logic clk;
  logic reset;
  logic [7:0] fetch_byte;
  logic fetch_step;
  logic sb_en;
  logic [7:0] sb[$];
  int total;
  int bad;
`ifdef PIPE_PERF_EN
  logic [31:0] perf_retired;
  logic [31:0] perf_stall;
`endif

  pipe_stage_ctrl_if #(.STAGES(5), .DATA_W(8)) pif ();

  pipe_stage_ctrl #(.STAGES(5), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif)
`ifdef PIPE_PERF_EN
    ,
    .perf_retired (perf_retired),
    .perf_stall   (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stage i>=1 passes on whatever sits in its input register; fetch drives the tag.
  always_comb pif.stage_bus = {pif.stage_bus_r[23:0], fetch_byte};

  // Scoreboard: push at fetch hand-off, pop and compare at retire.
  initial begin
    fetch_byte <= 8'hA5;
    fetch_step = 1'b0;
    forever begin
      @(posedge clk);
      if (fetch_step) fetch_byte <= fetch_byte + 8'd1;
      @(negedge clk);
      fetch_step = 1'b0;
      if (reset) begin
        sb.delete();
        fetch_byte <= 8'hA5;
      end else begin
        if (pif.advance[4] && sb_en) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL retire_order: retired %h, expected nothing outstanding", pif.stage_bus_r[31:24]);
          end else begin
            logic [7:0] exp_b;
            exp_b = sb.pop_front();
            if (pif.stage_bus_r[31:24] !== exp_b) begin
              bad++;
              $display("FAIL retire_order: got %h want %h", pif.stage_bus_r[31:24], exp_b);
            end
          end
        end
        if (pif.advance[0]) begin
          sb.push_back(fetch_byte);
          fetch_step = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pif.stage_over = 5'b11111;
    pif.flush = 1'b0;
    pif.flush_mask = 5'b00000;
    repeat (3) tick();
    total++; if (pif.stage_valid !== 5'b00000) begin bad++; $display("FAIL reset_valid: got %b want 00000", pif.stage_valid); end
    total++; if (pif.stage_bus_r !== 32'h0) begin bad++; $display("FAIL reset_bus: got %h want 00000000", pif.stage_bus_r); end
    total++; if (pif.allow_in !== 5'b11110) begin bad++; $display("FAIL reset_allow: got %b want 11110", pif.allow_in); end
    total++; if (pif.advance !== 5'b00000) begin bad++; $display("FAIL reset_advance: got %b want 00000", pif.advance); end
    total++; if (pif.next_fetch !== 1'b0) begin bad++; $display("FAIL reset_next_fetch: got %b want 0", pif.next_fetch); end
    pif.flush = 1'b1;
    #1;
    total++; if (pif.allow_in !== 5'b11111) begin bad++; $display("FAIL reset_flush_allow: got %b want 11111", pif.allow_in); end
    total++; if (pif.next_fetch !== 1'b1) begin bad++; $display("FAIL reset_flush_fetch: got %b want 1", pif.next_fetch); end
    pif.flush = 1'b0;
    #1;
  endtask

  task automatic test_fill();
    logic [4:0] exp_v;
    exp_v = 5'b00001;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (pif.stage_valid !== exp_v) begin bad++; $display("FAIL fill_valid[%0d]: got %b want %b", k, pif.stage_valid, exp_v); end
      if (k == 1) begin
        total++; if (pif.stage_bus_r[7:0] !== 8'hA5) begin bad++; $display("FAIL fill_bus0: got %h want a5", pif.stage_bus_r[7:0]); end
      end
      if (k == 4) begin
        total++; if (pif.stage_bus_r[31:24] !== 8'hA5) begin bad++; $display("FAIL fill_bus3: got %h want a5", pif.stage_bus_r[31:24]); end
      end
      exp_v = {exp_v[3:0], 1'b1};
    end
  endtask

  task automatic test_stall();
    pif.stage_over = 5'b01111;
    #1;
    total++; if (pif.allow_in !== 5'b00000) begin bad++; $display("FAIL stall_allow: got %b want 00000", pif.allow_in); end
    total++; if (pif.advance !== 5'b00000) begin bad++; $display("FAIL stall_advance: got %b want 00000", pif.advance); end
    total++; if (pif.next_fetch !== 1'b0) begin bad++; $display("FAIL stall_next_fetch: got %b want 0", pif.next_fetch); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (pif.stage_valid !== 5'b11111) begin bad++; $display("FAIL stall_valid[%0d]: got %b want 11111", k, pif.stage_valid); end
      total++; if (pif.stage_bus_r !== 32'hA5A6A7A8) begin bad++; $display("FAIL stall_bus[%0d]: got %h want a5a6a7a8", k, pif.stage_bus_r); end
      total++; if (pif.advance !== 5'b00000) begin bad++; $display("FAIL stall_hold_adv[%0d]: got %b want 00000", k, pif.advance); end
    end
    pif.stage_over = 5'b11111;
    #1;
    total++; if (pif.advance !== 5'b11111) begin bad++; $display("FAIL release_advance: got %b want 11111", pif.advance); end
    total++; if (pif.allow_in !== 5'b11111) begin bad++; $display("FAIL release_allow: got %b want 11111", pif.allow_in); end
    tick();
    total++; if (pif.stage_bus_r !== 32'hA6A7A8A9) begin bad++; $display("FAIL release_bus: got %h want a6a7a8a9", pif.stage_bus_r); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 60; k++) begin
      pif.stage_over = 5'($urandom) | 5'($urandom);
      tick();
    end
    pif.stage_over = 5'b11111;
    repeat (10) tick();
    total++; if (pif.stage_valid !== 5'b11111) begin bad++; $display("FAIL b2b_valid: got %b want 11111", pif.stage_valid); end
    total++; if (sb.size() != 4) begin bad++; $display("FAIL b2b_in_flight: got %0d want 4", sb.size()); end
  endtask

  task automatic test_flush_all();
    sb_en = 1'b0;
    pif.flush = 1'b1;
    pif.flush_mask = 5'b11110;
    #1;
    total++; if (pif.next_fetch !== 1'b1) begin bad++; $display("FAIL flush_next_fetch: got %b want 1", pif.next_fetch); end
    total++; if (pif.advance[3] !== 1'b1) begin bad++; $display("FAIL flush_concurrent_adv3: got %b want 1", pif.advance[3]); end
    tick();
    pif.flush = 1'b0;
    pif.flush_mask = 5'b00000;
    #1;
    total++; if (pif.stage_valid !== 5'b00001) begin bad++; $display("FAIL flush_all_valid: got %b want 00001", pif.stage_valid); end
    total++; if (pif.next_fetch !== 1'b1) begin bad++; $display("FAIL flush_refetch: got %b want 1", pif.next_fetch); end
    repeat (4) tick();
    total++; if (pif.stage_valid !== 5'b11111) begin bad++; $display("FAIL flush_refill: got %b want 11111", pif.stage_valid); end
  endtask

  task automatic test_flush_partial();
    pif.flush = 1'b1;
    pif.flush_mask = 5'b00110;
    #1;
    total++; if (pif.advance !== 5'b11111) begin bad++; $display("FAIL pflush_advance: got %b want 11111", pif.advance); end
    tick();
    pif.flush = 1'b0;
    pif.flush_mask = 5'b00000;
    #1;
    total++; if (pif.stage_valid !== 5'b11001) begin bad++; $display("FAIL pflush_valid0: got %b want 11001", pif.stage_valid); end
    tick();
    total++; if (pif.stage_valid !== 5'b10011) begin bad++; $display("FAIL pflush_valid1: got %b want 10011", pif.stage_valid); end
  endtask

  task automatic test_bubble();
    reset = 1'b1;
    pif.stage_over = 5'b11111;
    repeat (2) tick();
    reset = 1'b0;
    sb_en = 1'b1;
    repeat (2) tick();
    pif.stage_over = 5'b00100;
    #1;
    total++; if (pif.advance !== 5'b00000) begin bad++; $display("FAIL bubble_advance: got %b want 00000", pif.advance); end
    total++; if (pif.allow_in !== 5'b11100) begin bad++; $display("FAIL bubble_allow: got %b want 11100", pif.allow_in); end
    tick();
    total++; if (pif.stage_valid !== 5'b00011) begin bad++; $display("FAIL bubble_valid: got %b want 00011", pif.stage_valid); end
    total++; if (pif.stage_bus_r !== 32'h000000A5) begin bad++; $display("FAIL bubble_bus: got %h want 000000a5", pif.stage_bus_r); end
  endtask

  task automatic test_reset_mid();
    pif.stage_over = 5'b11111;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    total++; if (pif.stage_valid !== 5'b00000) begin bad++; $display("FAIL midreset_valid: got %b want 00000", pif.stage_valid); end
    total++; if (pif.stage_bus_r !== 32'h0) begin bad++; $display("FAIL midreset_bus: got %h want 00000000", pif.stage_bus_r); end
  endtask

  task automatic test_perf();
`ifdef PIPE_PERF_EN
    total++; if (perf_retired !== 32'd0) begin bad++; $display("FAIL perf_reset_retired: got %0d want 0", perf_retired); end
    total++; if (perf_stall !== 32'd0) begin bad++; $display("FAIL perf_reset_stall: got %0d want 0", perf_stall); end
    reset = 1'b0;
    repeat (15) tick();
    total++; if (perf_retired !== 32'd10) begin bad++; $display("FAIL perf_retired: got %0d want 10", perf_retired); end
    total++; if (perf_stall !== 32'd0) begin bad++; $display("FAIL perf_stall: got %0d want 0", perf_stall); end
`else
    reset = 1'b0;
    repeat (2) tick();
`endif
  endtask

  initial begin
    total = 0;
    bad = 0;
    sb_en = 1'b1;
    reset = 1'b1;
    pif.stage_over = '0;
    pif.flush = 1'b0;
    pif.flush_mask = '0;
    test_reset();
    test_fill();
    test_stall();
    test_back_to_back();
    test_flush_all();
    test_flush_partial();
    test_bubble();
    test_reset_mid();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
